// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_arb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int MAX_REQ    = 4;
  localparam int GIDX_W     = $clog2(MAX_REQ);

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [GIDX_W-1:0]     gidx_t;

  // One-hot mask selecting a single architectural register in the busy vector.
  function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward,
// wrapping modulo NUM_REQ, and grants the first valid requester.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  gidx_t              last_grant_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output gidx_t              gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [GIDX_W:0]    pos;

  always_comb begin
    // NOTE: every signal gets a default before any conditional write, so no latch is inferred.
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_i;
    pos                  = '0;
    gnt_valid_o          = 1'b0;
    gnt_idx_o            = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = {1'b0, last_grant_i} + (GIDX_W+1)'(k);
      if (pos >= (GIDX_W+1)'(NUM_REQ)) pos = pos - (GIDX_W+1)'(NUM_REQ);
      if (!gnt_valid_o && req_ext[pos[GIDX_W-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = pos[GIDX_W-1:0];
      end
    end
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = gnt_valid_o && (gnt_idx_o == gidx_t'(i));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the register file's single write port.
// Optional REGFILE_WB_BYPASS_EN adds forwarding of the in-flight write to rs1/rs2.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          alloc_valid,
  input  reg_idx_t                      alloc_rd,
  output logic                          alloc_ok,
  input  reg_idx_t                      rs1,
  input  reg_idx_t                      rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          rf_reg_write,
  output reg_idx_t                      rf_rd,
  output logic [XLEN-1:0]               rf_write_data,
  output logic [NUM_REGS-1:0]           busy_vec
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                          rs1_fwd_valid,
  output logic [XLEN-1:0]               rs1_fwd_data,
  output logic                          rs2_fwd_valid,
  output logic [XLEN-1:0]               rs2_fwd_data
`endif
);

  gidx_t               last_grant_q, last_grant_d;
  logic                rf_reg_write_q, rf_reg_write_d;
  reg_idx_t            rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]     rf_write_data_q, rf_write_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [NUM_REQ-1:0]  gnt;
  gidx_t               gnt_idx;
  logic                gnt_valid;
  logic                xfer;
  reg_idx_t            sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic                rs1_sb, rs2_sb;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  assign req_ready = rst ? '0 : gnt;
  assign xfer      = gnt_valid && !rst;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == gidx_t'(i)) begin
        sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // A register being written back this cycle frees up at the edge, so a new
  // reservation for it can be taken at the same edge.
  assign alloc_ok = !rst && alloc_valid &&
                    (alloc_rd == '0 || !busy_q[alloc_rd] ||
                     (rf_reg_write_q && rf_rd_q == alloc_rd));

  always_comb begin
    last_grant_d    = xfer ? gnt_idx : last_grant_q;
    rf_reg_write_d  = xfer && (sel_rd != '0);
    rf_rd_d         = xfer ? sel_rd : rf_rd_q;
    rf_write_data_d = xfer ? sel_data : rf_write_data_q;
    busy_d          = busy_q;
    if (rf_reg_write_q) busy_d = busy_d & ~idx_onehot(rf_rd_q);
    if (alloc_ok && alloc_rd != '0) busy_d = busy_d | idx_onehot(alloc_rd);
    busy_d[0]       = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: busy is a plain flop vector rather than a RAM, so it takes a reset like any register.
      last_grant_q    <= gidx_t'(NUM_REQ-1);
      rf_reg_write_q  <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
      busy_q          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      last_grant_q    <= last_grant_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_rd_q         <= rf_rd_d;
      rf_write_data_q <= rf_write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign rf_reg_write  = rf_reg_write_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;
  assign busy_vec      = busy_q;

  assign rs1_sb = (rs1 != '0) && busy_q[rs1];
  assign rs2_sb = (rs2 != '0) && busy_q[rs2];

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_fwd_valid = rf_reg_write_q && (rf_rd_q == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = rf_reg_write_q && (rf_rd_q == rs2) && (rs2 != '0);
  assign rs1_fwd_data  = rf_write_data_q;
  assign rs2_fwd_data  = rf_write_data_q;
  // A forwarded operand is not a hazard, so the consumer can issue one cycle early.
  assign rs1_busy      = rs1_sb && !rs1_fwd_valid;
  assign rs2_busy      = rs2_sb && !rs2_fwd_valid;
`else
  assign rs1_busy      = rs1_sb;
  assign rs2_busy      = rs2_sb;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a cycle model predicts grants, the
// write-port queue and the busy vector; directed sequences cover the corner cases.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*5-1:0]    req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    alloc_valid;
  logic [4:0]              alloc_rd;
  logic                    alloc_ok;
  logic [4:0]              rs1, rs2;
  logic                    rs1_busy, rs2_busy;
  logic                    rf_reg_write;
  logic [4:0]              rf_rd;
  logic [XLEN-1:0]         rf_write_data;
  logic [31:0]             busy_vec;
`ifdef REGFILE_WB_BYPASS_EN
  logic                    rs1_fwd_valid, rs2_fwd_valid;
  logic [XLEN-1:0]         rs1_fwd_data, rs2_fwd_data;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .alloc_valid   (alloc_valid),
    .alloc_rd      (alloc_rd),
    .alloc_ok      (alloc_ok),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rf_reg_write  (rf_reg_write),
    .rf_rd         (rf_rd),
    .rf_write_data (rf_write_data),
    .busy_vec      (busy_vec)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs2_fwd_data  (rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 1'b0;

  wr_t exp_q[$];
  wr_t wr_log[$];
  int  gnt_log[$];

  int          m_last   = NUM_REQ-1;
  bit          exp_wr   = 1'b0;
  wr_t         cur      = '0;
  logic [31:0] exp_busy = '0;
  bit          p_gok    = 1'b0;
  int          p_gidx   = 0;
  bit          p_wr     = 1'b0;
  logic [31:0] p_busy   = '0;
  logic [XLEN-1:0] rf_model [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    req_valid[i]            = v;
    req_rd[i*5 +: 5]        = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  // Commit the prediction made at the previous falling edge; model the register file.
  always @(posedge clk) begin
    if (rf_reg_write === 1'b1) rf_model[rf_rd] = rf_write_data;
    if (rst) begin
      m_last   = NUM_REQ-1;
      exp_wr   = 1'b0;
      exp_q.delete();
      exp_busy = '0;
    end else begin
      if (p_gok) m_last = p_gidx;
      exp_wr = p_wr;
      if (p_wr) cur = exp_q.pop_front();
      exp_busy = p_busy;
    end
    p_gok = 1'b0;
    p_wr  = 1'b0;
  end

  // Check every output against the model, then predict the next cycle.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    int                 gi;
    bit                 gok, aok, f1, f2;
    logic [31:0]        nb;
    wr_t                w;
    if (mon_en) begin
      eg  = '0;
      gi  = 0;
      gok = 1'b0;
      if (!rst) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (!gok && req_valid[c]) begin
            gok = 1'b1;
            gi  = c;
          end
        end
      end
      if (gok) eg[gi] = 1'b1;
      check("req_ready", req_ready, eg);
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gnt_log.push_back(i);

      check("rf_reg_write", rf_reg_write, exp_wr);
      if (exp_wr) begin
        check("rf_rd", rf_rd, cur.rd);
        check("rf_write_data", rf_write_data, cur.data);
      end
      if (rf_reg_write) wr_log.push_back({rf_rd, rf_write_data});
      check("busy_vec", busy_vec, exp_busy);

      aok = !rst && alloc_valid &&
            (alloc_rd == 0 || !exp_busy[alloc_rd] || (exp_wr && cur.rd == alloc_rd));
      check("alloc_ok", alloc_ok, aok);

      f1 = 1'b0;
      f2 = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
      f1 = exp_wr && cur.rd == rs1 && rs1 != 0;
      f2 = exp_wr && cur.rd == rs2 && rs2 != 0;
      check("rs1_fwd_valid", rs1_fwd_valid, f1);
      check("rs2_fwd_valid", rs2_fwd_valid, f2);
      if (f1) check("rs1_fwd_data", rs1_fwd_data, cur.data);
      if (f2) check("rs2_fwd_data", rs2_fwd_data, cur.data);
`endif
      check("rs1_busy", rs1_busy, (rs1 != 0) && exp_busy[rs1] && !f1);
      check("rs2_busy", rs2_busy, (rs2 != 0) && exp_busy[rs2] && !f2);

      p_gok  = gok;
      p_gidx = gi;
      p_wr   = 1'b0;
      if (gok) begin
        w.rd   = req_rd[gi*5 +: 5];
        w.data = req_data[gi*XLEN +: XLEN];
        if (w.rd != 0) begin
          exp_q.push_back(w);
          p_wr = 1'b1;
        end
      end
      nb = exp_busy;
      if (exp_wr) nb[cur.rd] = 1'b0;
      if (aok && alloc_rd != 0) nb[alloc_rd] = 1'b1;
      nb[0]  = 1'b0;
      p_busy = nb;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    rst = 1'b1;
    req_valid = '0; req_rd = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0; rs1 = '0; rs2 = '0;

    // Reset held two cycles with both requesters asking.
    drive(0, 1'b1, 5'd5, 32'hA);
    drive(1, 1'b1, 5'd6, 32'hB);
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rf_wr", rf_reg_write, 0);
    check("rst_busy", busy_vec, 0);
    tick();

    // Round-robin: grants alternate starting with requester 0.
    rst = 1'b0;
    gnt_log.delete();
    wr_log.delete();
    repeat (4) tick();
    req_valid = '0;
    tick();
    check("rr_gnt_count", gnt_log.size(), 4);
    check("rr_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size() && i < wr_log.size(); i++) begin
      check("rr_gnt", gnt_log[i], i % 2);
      check("rr_wr_rd", wr_log[i].rd, (i % 2) ? 5'd6 : 5'd5);
      check("rr_wr_data", wr_log[i].data, (i % 2) ? 32'hB : 32'hA);
    end

    // Scoreboard lifecycle on x7.
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    @(negedge clk); check("alloc7_ok", alloc_ok, 1);
    tick();
    alloc_valid = 1'b0; rs1 = 5'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check("rs1_busy_wait", rs1_busy, 1);
      tick();
    end
    drive(0, 1'b1, 5'd7, 32'h1234);
    @(negedge clk);
    check("g7_ready", req_ready, 2'b01);
    check("g7_rs1_busy", rs1_busy, 1);
    tick();
    drive(0, 1'b0, 5'd7, 32'h1234);
    @(negedge clk);
    check("g7_wr", rf_reg_write, 1);
`ifdef REGFILE_WB_BYPASS_EN
    check("g7_rs1_busy_t1", rs1_busy, 0);
`else
    check("g7_rs1_busy_t1", rs1_busy, 1);
`endif
    tick();
    @(negedge clk); check("g7_rs1_busy_t2", rs1_busy, 0);
    tick();
    check("x7_rf", rf_model[7], 32'h1234);

    // WAW refusal, then same-edge clear and re-alloc of x9.
    rs2 = 5'd9;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    @(negedge clk); check("alloc9_first", alloc_ok, 1);
    tick();
    @(negedge clk);
    check("alloc9_waw", alloc_ok, 0);
    check("rs2_busy9", rs2_busy, 1);
    tick();
    alloc_valid = 1'b0;
    drive(0, 1'b1, 5'd9, 32'h99);
    @(negedge clk); check("g9_ready", req_ready, 2'b01);
    tick();
    drive(0, 1'b0, 5'd9, 32'h99);
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    @(negedge clk);
    check("g9_wr", rf_reg_write, 1);
    check("alloc9_same_edge", alloc_ok, 1);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk); check("busy9_kept", busy_vec[9], 1);
    tick();

    // x0 write-back and x0 alloc leave the scoreboard alone.
    drive(0, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk); check("x0_ready", req_ready, 2'b01);
    tick();
    drive(0, 1'b0, 5'd0, 32'hFFFF);
    @(negedge clk);
    check("x0_no_wr", rf_reg_write, 0);
    check("x0_busy", busy_vec, 32'h200);
    tick();
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    @(negedge clk); check("alloc0_ok", alloc_ok, 1);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk); check("alloc0_busy", busy_vec, 32'h200);
    tick();

    // Dependent read of an in-flight write that was never allocated.
    rs1 = 5'd11;
    drive(1, 1'b1, 5'd11, 32'hBEEF);
    @(negedge clk); check("g11_ready", req_ready, 2'b10);
    tick();
    drive(1, 1'b0, 5'd11, 32'hBEEF);
    @(negedge clk);
    check("g11_wr", rf_reg_write, 1);
    check("g11_rs1_busy", rs1_busy, 0);
`ifdef REGFILE_WB_BYPASS_EN
    check("g11_fwd_valid", rs1_fwd_valid, 1);
    check("g11_fwd_data", rs1_fwd_data, 32'hBEEF);
`endif
    tick();

    // Reset lands on the edge that would have registered a granted write.
    rs1 = 5'd0;
    drive(0, 1'b1, 5'd10, 32'h55);
    @(negedge clk); check("g10_ready", req_ready, 2'b01);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 5'd10, 32'h55);
    tick();
    @(negedge clk);
    check("rstw_no_wr", rf_reg_write, 0);
    check("rstw_busy", busy_vec, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("x10_rf", rf_model[10], 0);
    check("x9_rf", rf_model[9], 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the single write port of `register_file`. Up to four write-back sources (ALU, load unit, CSR/mul units) compete for the port. The block grants them round-robin and registers the winning write onto the port. A 32-entry busy scoreboard tells the issue stage which architectural registers have a write outstanding.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of write-back requesters. Legal range is 1–4.
- `XLEN`, default 32: data width.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `req_valid`, in, NUM_REQ: requester i has a write pending.
- `req_rd`, in, NUM_REQ*5: destination of requester i, packed at bits [5i+4:5i].
- `req_data`, in, NUM_REQ*XLEN: write data of requester i, packed.
- `req_ready`, out, NUM_REQ: one-hot grant, combinational.
- `alloc_valid`, in, 1: issue stage reserves `alloc_rd`.
- `alloc_rd`, in, 5: register to mark busy.
- `alloc_ok`, out, 1: reservation accepted, combinational.
- `rs1`, in, 5: read index to check.
- `rs2`, in, 5: read index to check.
- `rs1_busy`, out, 1: hazard flag for `rs1`, combinational.
- `rs2_busy`, out, 1: hazard flag for `rs2`, combinational.
- `rf_reg_write`, out, 1: to `register_file.reg_write`, registered.
- `rf_rd`, out, 5: to `register_file.rd`, registered.
- `rf_write_data`, out, XLEN: to `register_file.write_data`, registered.
- `busy_vec`, out, 32: scoreboard state, registered. Bit 0 is always 0.

## Operation
**Requester handshake**
- Valid/ready handshake. Once `req_valid[i]` is high, it and its `rd`/`data` stay stable until `req_ready[i]`.
- A transfer occurs when `valid & ready` are both high.
- At most one `req_ready` bit is high per cycle.

**Arbitration**
- Round-robin. State is `last_grant`, an index register.
- Search order is `last_grant+1`, `last_grant+2`, … modulo NUM_REQ. The first valid requester wins.
- `last_grant` updates only on a transfer.
- A lone requester is granted every cycle, giving back-to-back throughput of one write per cycle.

**Write port**
- A transfer in cycle T loads the `rf_*` registers, so `rf_reg_write=1` in T+1.
- If there is no transfer in T, `rf_reg_write=0` in T+1. `rf_rd` and `rf_write_data` hold their previous values.
- A transfer with `rd==0` is accepted and consumed. It produces `rf_reg_write=0` and no scoreboard change.

**Scoreboard**
- Set: `busy[alloc_rd]` is set at the edge when `alloc_valid & alloc_ok` and `alloc_rd!=0`.
- Clear: `busy[rf_rd]` is cleared at the edge ending a cycle where `rf_reg_write=1`.
- `alloc_ok = alloc_valid & (alloc_rd==0 | !busy[alloc_rd] | (rf_reg_write & rf_rd==alloc_rd))`. This refuses WAW on an outstanding register.
- Same-edge set and clear of the same register: the set wins, so the bit stays 1.
- `rsN_busy = (rsN!=0) & busy[rsN]`.
- A write-back to a register that is not busy (no prior alloc) is legal. It writes, and the clear is a no-op.

**Reset (`rst` high at an edge)**
- Reset values: `busy_vec=0`, `rf_reg_write=0`, `rf_rd=0`, `rf_write_data=0`, `last_grant=NUM_REQ-1`, so requester 0 has first priority.
- While `rst` is high, `req_ready=0` and `alloc_ok=0`.
- A write registered before reset is dropped and never reaches `register_file`.

## Timing
- Grant latency is 0 cycles: ready is asserted in the same cycle as valid when the requester wins.
- Grant to write-port assertion: 1 cycle.
- Write port to register-file commit: at the edge ending T+1.
- `busy` clears at that same edge, so `rsN_busy` drops in T+2, which is when `register_file` reads return the new value.
- Alloc at the edge ending cycle A makes `rsN_busy` high from A+1.

## Configuration
`REGFILE_WB_BYPASS_EN`
- **Defined**: adds outputs `rs1_fwd_valid`, `rs1_fwd_data`, `rs2_fwd_valid`, `rs2_fwd_data`.
  - `rsN_fwd_valid = rf_reg_write & rf_rd==rsN & rsN!=0`.
  - `rsN_fwd_data = rf_write_data`.
  - In this case `rsN_busy` is forced low, so the dependent instruction issues in T+1 instead of T+2.
- **Undefined**: the ports are absent and `rsN_busy` follows the scoreboard only.

## Structure
- Package `regfile_arb_pkg` holds:
  - `XLEN_DEF`=32, `REG_ADDR_W`=5, `NUM_REGS`=32, `MAX_REQ`=4.
  - typedef `reg_idx_t` (5 bits).
- Sub-module `rr_arbiter`: parameterised NUM_REQ. Inputs are the request vector and `last_grant`; outputs are the one-hot grant and the grant index. It is purely combinational.
- Pointer, scoreboard and write registers live in the top.

## Test plan
1. Reset:
   - Stimulus: drive `rst=1` for 2 cycles with `req_valid=2'b11`.
   - Required: `req_ready=0`, `rf_reg_write=0`, `busy_vec=0`.
   - After release, requester 0 is granted first.
2. Round-robin:
   - Stimulus: both requesters hold valid, req0 rd=5/data=0xA, req1 rd=6/data=0xB, for 4 cycles.
   - Required: grants alternate 0,1,0,1.
   - Write port shows x5=0xA, x6=0xB, x5, x6 in consecutive cycles, each one cycle after its grant.
3. Scoreboard lifecycle:
   - Stimulus: alloc rd=7, then with `rs1=7` the ALU writes x7=0x1234 four cycles later.
   - Required: `rs1_busy=1` from the cycle after alloc until 2 cycles after the grant, then 0.
   - `register_file` reads x7=0x1234.
4. WAW and same-edge cases:
   - Stimulus: alloc rd=9 twice while busy.
   - Required: the second `alloc_ok=0`.
   - Stimulus: alloc rd=9 in the same cycle as `rf_reg_write` for x9.
   - Required: `alloc_ok=1` and `busy[9]` remains 1.
5. x0 handling:
   - Stimulus: write-back with rd=0, data=0xFFFF.
   - Required: `req_ready=1`, `rf_reg_write=0` next cycle, `busy_vec` unchanged.
   - Stimulus: alloc rd=0.
   - Required: `alloc_ok=1`, `busy_vec[0]=0`.
6. Reset mid-write, with and without `REGFILE_WB_BYPASS_EN`:
   - Stimulus: a grant in cycle T, then `rst` at the edge ending T.
   - Required: `rf_reg_write=0` in T+1 and no register write occurs.
   - Bypass build: `rs1=rf_rd` during an active write gives `rs1_fwd_valid=1` with matching data and `rs1_busy=0`.
